pool_arbiter: RTL

- Round-robin scheduler that shares one pool_layer instance among NUM_REQ requesting conv cores.
- Grants one requester at a time and drives the pool layer's single-cycle start.
- Waits for the pool layer's done, then returns completion to the granted core.
- Sits between the conv-core array and the shared pooling datapath. grant_id drives the external input_fm/output_fm muxes.

---
 rtl/pool_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pool_arbiter.sv
// pool_arbiter: round-robin share of one pool_layer among NUM_REQ conv cores.
// Ports: clk, rst (async, active-high); req/gnt/grant_id/req_done per core;
//   pool_start/pool_done to the pool layer; timeout_err abort pulse; busy.
// Optional: define POOL_ARB_TIMEOUT_EN to abort RUN after TIMEOUT cycles.
module pool_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 255,
   parameter int TMO_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    grant_id,
   output logic               pool_start,
   input  logic               pool_done,
   output logic [NUM_REQ-1:0] req_done,
   output logic               timeout_err,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN,
      RELEASE
   } state_t;

   state_t             state;
   state_t             state_n;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    ptr_n;
   logic [NUM_REQ-1:0] gnt_n;
   logic [ID_W-1:0]    id_n;
   logic               start_n;
   logic [NUM_REQ-1:0] done_n;
   logic               done_q;
   logic               done_rise;
   logic               found;
   logic [ID_W-1:0]    pick;
   logic [ID_W-1:0]    idx;
   logic               tmo_hit;

   if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) ||
       TIMEOUT >= (1 << TMO_W)) begin : g_param_chk
      $error("pool_arbiter: inconsistent parameters");
   end

   // A done level left over from the previous job never ends a new one.
   assign done_rise = pool_done & ~done_q;

   // First requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      id_n    = grant_id;
      ptr_n   = ptr;
      start_n = 1'b0;
      done_n  = '0;
      unique case (state)
         IDLE: begin
            if (found) begin
               gnt_n       = '0;
               gnt_n[pick] = 1'b1;
               id_n        = pick;
               state_n     = START;
            end
         end
         START: begin
            start_n = 1'b1;
            state_n = RUN;
         end
         RUN: begin
            if (done_rise || tmo_hit) begin
               done_n  = gnt;
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            gnt_n   = '0;
            ptr_n   = (grant_id == ID_W'(NUM_REQ - 1)) ?
                      '0 : grant_id + 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         gnt        <= '0;
         grant_id   <= '0;
         ptr        <= '0;
         pool_start <= 1'b0;
         req_done   <= '0;
         busy       <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_n;
         gnt        <= gnt_n;
         grant_id   <= id_n;
         ptr        <= ptr_n;
         pool_start <= start_n;
         req_done   <= done_n;
         busy       <= (state_n != IDLE);
         done_q     <= pool_done;
      end
   end

`ifdef POOL_ARB_TIMEOUT_EN
   logic [TMO_W-1:0] cnt;
   logic             tmo_q;

   // cnt is 0 in the first RUN cycle, so the abort edge lands
   // TIMEOUT cycles after RUN was entered.
   assign tmo_hit = (state == RUN) &&
                    (cnt == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         tmo_q <= 1'b0;
      end else begin
         // A real completion in the limit cycle wins over the abort.
         tmo_q <= tmo_hit && !done_rise;
         if (state == START) begin
            cnt <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign timeout_err = tmo_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
